// File: rtl/alu_result_6502_pkg.sv
// Shared definitions for the 6502 ALU result/flag stage: P bit positions,
// adjust and flag-select encodings, the stage-1 control bundle and the BCD nibble offset.
package alu_result_6502_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    localparam logic [1:0] ADJ_NONE = 2'b00;
    localparam logic [1:0] ADJ_ADC  = 2'b01;
    localparam logic [1:0] ADJ_SBC  = 2'b10;

    localparam logic [1:0] SEL_C = 2'b00;
    localparam logic [1:0] SEL_I = 2'b01;
    localparam logic [1:0] SEL_D = 2'b10;
    localparam logic [1:0] SEL_V = 2'b11;

    localparam logic [7:0] P_RESET = 8'h34;

    // Per-op controls captured at the issue edge and consumed one edge later.
    typedef struct packed {
        logic [1:0] adj_op;
        logic       upd_nz;
        logic       upd_c;
        logic       upd_v;
        logic       bit_op;
        logic       p_load;
        logic       flag_we;
        logic [1:0] flag_sel;
        logic       flag_val;
        logic [7:0] mem;
    } s1_ctl_t;

    // Offset added to one nibble; carry is the ALU's carry out of that nibble.
    function automatic logic [3:0] bcd_offset(input logic [1:0] adj, input logic carry);
        logic [3:0] off;
        off = 4'h0;
        case (adj)
            ADJ_ADC: off = carry ? 4'h6 : 4'h0;
            ADJ_SBC: off = carry ? 4'h0 : 4'hA;
            default: off = 4'h0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/bcd_adjust_6502.sv
// Decimal adjust of the ALU binary result, purely combinational.
// Each nibble gets its own offset mod 16; no carry crosses between nibbles.
module bcd_adjust_6502
    import alu_result_6502_pkg::*;
(
    input  logic [7:0] alu_out,
    input  logic       hc,
    input  logic       co,
    input  logic [1:0] adj_op,
    output logic [7:0] res_adj
);

    logic [3:0] lo;
    logic [3:0] hi;

    always_comb begin
        lo      = alu_out[3:0] + bcd_offset(adj_op, hc);
        hi      = alu_out[7:4] + bcd_offset(adj_op, co);
        res_adj = {hi, lo};
    end

endmodule

// File: rtl/alu_result_6502.sv
// 6502 result/flag stage: controls issued at T are aligned with ALU outputs at T+1; res and P update at the T+2 edge.
// RDY low freezes every register (irq_set_i included); there is no other backpressure.
module alu_result_6502
    import alu_result_6502_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       RDY,
    input  logic       ctl_valid,
    input  logic [1:0] adj_op,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       bit_op,
    input  logic       p_load,
    input  logic       flag_we,
    input  logic [1:0] flag_sel,
    input  logic       flag_val,
    input  logic [7:0] mem_in,
    input  logic       irq_set_i,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       alu_hc,
    output logic [7:0] res,
    output logic       res_valid,
    output logic [7:0] P,
    output logic       c_flag,
    output logic       d_flag
);

    s1_ctl_t    ctl_in;
    s1_ctl_t    s1;
    logic       s1_valid;
    logic [7:0] res_adj;
    logic [7:0] p_nx;

    always_comb begin
        ctl_in          = '0;
        ctl_in.adj_op   = adj_op;
        ctl_in.upd_nz   = upd_nz;
        ctl_in.upd_c    = upd_c;
        ctl_in.upd_v    = upd_v;
        ctl_in.bit_op   = bit_op;
        ctl_in.p_load   = p_load;
        ctl_in.flag_we  = flag_we;
        ctl_in.flag_sel = flag_sel;
        ctl_in.flag_val = flag_val;
        ctl_in.mem      = mem_in;
    end

    bcd_adjust_6502 u_bcd (
        .alu_out (alu_out),
        .hc      (alu_hc),
        .co      (alu_co),
        .adj_op  (s1.adj_op),
        .res_adj (res_adj)
    );

    // Later assignments win: ALU-driven updates, then BIT, then explicit
    // flag write; p_load replaces all of them; interrupt entry sits on top.
    always_comb begin
        p_nx = P;
        if (s1_valid) begin
            if (s1.p_load) begin
                p_nx = s1.mem;
            end else begin
                if (s1.upd_nz) begin
                    p_nx[FLAG_N] = alu_n;
                    p_nx[FLAG_Z] = alu_z;
                end
                if (s1.upd_c) begin
                    p_nx[FLAG_C] = alu_co;
                end
                if (s1.upd_v) begin
                    p_nx[FLAG_V] = alu_v;
                end
                if (s1.bit_op) begin
                    p_nx[FLAG_N] = s1.mem[7];
                    p_nx[FLAG_V] = s1.mem[6];
                    p_nx[FLAG_Z] = alu_z;
                end
                if (s1.flag_we) begin
                    case (s1.flag_sel)
                        SEL_C:   p_nx[FLAG_C] = s1.flag_val;
                        SEL_I:   p_nx[FLAG_I] = s1.flag_val;
                        SEL_D:   p_nx[FLAG_D] = s1.flag_val;
                        default: p_nx[FLAG_V] = s1.flag_val;
                    endcase
                end
            end
        end
        if (irq_set_i) begin
            p_nx[FLAG_I] = 1'b1;
        end
        p_nx[5]      = 1'b1;
        p_nx[FLAG_B] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (RDY) begin
            s1_valid <= ctl_valid;
            s1       <= ctl_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res       <= 8'h00;
            res_valid <= 1'b0;
            P         <= P_RESET;
        end else if (RDY) begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                res <= res_adj;
            end
            P <= p_nx;
        end
    end

    assign c_flag = P[FLAG_C];
    assign d_flag = P[FLAG_D];

endmodule

// File: tb/tb_alu_result_6502.sv
// Streams a table of ops through the stage with a modelled ALU register;
// expected res/P per op are hand-derived constants queued at issue and popped at completion.
module tb_alu_result_6502;

    typedef struct packed {
        logic [1:0] adj;
        logic       nz;
        logic       c;
        logic       v;
        logic       bop;
        logic       pl;
        logic       fwe;
        logic [1:0] fsel;
        logic       fval;
        logic [7:0] mem;
        logic [7:0] ao;
        logic       co;
        logic       av;
        logic       az;
        logic       an;
        logic       hc;
        logic       irq;
        logic [7:0] exp_res;
        logic [7:0] exp_p;
    } op_t;

    logic       clk;
    logic       reset;
    logic       RDY;
    logic       ctl_valid;
    logic [1:0] adj_op;
    logic       upd_nz;
    logic       upd_c;
    logic       upd_v;
    logic       bit_op;
    logic       p_load;
    logic       flag_we;
    logic [1:0] flag_sel;
    logic       flag_val;
    logic [7:0] mem_in;
    logic       irq_set_i;
    logic [7:0] alu_out;
    logic       alu_co;
    logic       alu_v;
    logic       alu_z;
    logic       alu_n;
    logic       alu_hc;
    logic [7:0] res;
    logic       res_valid;
    logic [7:0] P;
    logic       c_flag;
    logic       d_flag;

    int n_chk  = 0;
    int n_pass = 0;

    op_t        ops[$];
    logic [7:0] exp_res_q[$];
    logic [7:0] exp_p_q[$];

    alu_result_6502 dut (
        .clk       (clk),
        .reset     (reset),
        .RDY       (RDY),
        .ctl_valid (ctl_valid),
        .adj_op    (adj_op),
        .upd_nz    (upd_nz),
        .upd_c     (upd_c),
        .upd_v     (upd_v),
        .bit_op    (bit_op),
        .p_load    (p_load),
        .flag_we   (flag_we),
        .flag_sel  (flag_sel),
        .flag_val  (flag_val),
        .mem_in    (mem_in),
        .irq_set_i (irq_set_i),
        .alu_out   (alu_out),
        .alu_co    (alu_co),
        .alu_v     (alu_v),
        .alu_z     (alu_z),
        .alu_n     (alu_n),
        .alu_hc    (alu_hc),
        .res       (res),
        .res_valid (res_valid),
        .P         (P),
        .c_flag    (c_flag),
        .d_flag    (d_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    endtask

    function automatic op_t mk(input logic [1:0] adj, input logic nz, input logic c, input logic v,
                               input logic bop, input logic pl, input logic fwe, input logic [1:0] fsel,
                               input logic fval, input logic [7:0] mem, input logic [7:0] ao,
                               input logic co, input logic av, input logic az, input logic an,
                               input logic hc, input logic irq, input logic [7:0] er, input logic [7:0] ep);
        op_t o;
        o = '{adj, nz, c, v, bop, pl, fwe, fsel, fval, mem, ao, co, av, az, an, hc, irq, er, ep};
        return o;
    endfunction

    task automatic drive_ctl(input op_t o, input logic vld);
        ctl_valid = vld;
        adj_op    = o.adj;
        upd_nz    = o.nz;
        upd_c     = o.c;
        upd_v     = o.v;
        bit_op    = o.bop;
        p_load    = o.pl;
        flag_we   = o.fwe;
        flag_sel  = o.fsel;
        flag_val  = o.fval;
        mem_in    = o.mem;
    endtask

    task automatic drive_alu(input op_t o);
        alu_out   = o.ao;
        alu_co    = o.co;
        alu_v     = o.av;
        alu_z     = o.az;
        alu_n     = o.an;
        alu_hc    = o.hc;
        irq_set_i = o.irq;
    endtask

    initial begin
        op_t        cur;
        op_t        zero_op;
        logic [7:0] last_res;
        logic [7:0] er;
        logic [7:0] ep;
        zero_op = '0;

        //        adj   nz c  v  bit pl fwe fsel  fv mem    alu    co av az an hc irq res    P
        ops.push_back(mk(2'b00, 1, 1, 1, 0, 0, 0, 2'b00, 0, 8'h00, 8'h80, 0, 1, 0, 1, 0, 0, 8'h80, 8'hF4));
        ops.push_back(mk(2'b01, 1, 1, 1, 0, 0, 1, 2'b10, 1, 8'h00, 8'h4C, 0, 0, 0, 0, 1, 0, 8'h42, 8'h3C));
        ops.push_back(mk(2'b10, 1, 1, 0, 0, 0, 0, 2'b00, 0, 8'h00, 8'h2D, 1, 0, 0, 0, 0, 0, 8'h27, 8'h3D));
        ops.push_back(mk(2'b00, 0, 1, 0, 0, 1, 0, 2'b00, 0, 8'h00, 8'h11, 1, 0, 0, 0, 0, 0, 8'h11, 8'h30));
        ops.push_back(mk(2'b00, 0, 1, 0, 0, 1, 0, 2'b00, 0, 8'h00, 8'h22, 1, 0, 0, 0, 0, 1, 8'h22, 8'h34));
        ops.push_back(mk(2'b00, 0, 1, 0, 0, 0, 1, 2'b00, 1, 8'h00, 8'h33, 0, 0, 0, 0, 0, 0, 8'h33, 8'h35));
        ops.push_back(mk(2'b00, 1, 0, 0, 1, 0, 0, 2'b00, 0, 8'hC0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 8'hF7));
        ops.push_back(mk(2'b01, 1, 1, 0, 0, 0, 0, 2'b00, 0, 8'h00, 8'hA3, 1, 0, 0, 1, 0, 0, 8'h03, 8'hF5));
        ops.push_back(mk(2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 8'h00, 8'h9A, 1, 0, 0, 0, 1, 0, 8'h9A, 8'hF5));
        ops.push_back(mk(2'b10, 0, 0, 1, 0, 0, 1, 2'b01, 0, 8'h00, 8'h5F, 0, 0, 0, 0, 1, 0, 8'hFF, 8'hB1));
        ops.push_back(mk(2'b00, 1, 0, 0, 0, 1, 0, 2'b00, 0, 8'h0F, 8'h01, 0, 0, 0, 1, 0, 0, 8'h01, 8'h3F));
        ops.push_back(mk(2'b00, 0, 0, 1, 0, 0, 1, 2'b11, 1, 8'h00, 8'h02, 0, 0, 0, 0, 0, 0, 8'h02, 8'h7F));
        ops.push_back(mk(2'b00, 0, 0, 0, 0, 0, 1, 2'b01, 0, 8'h00, 8'h44, 0, 0, 0, 0, 0, 0, 8'h44, 8'h7B));

        reset = 1'b1;
        RDY   = 1'b1;
        drive_ctl(zero_op, 1'b0);
        drive_alu(zero_op);
        #2;
        chk("rst_p", P, 8'h34);
        chk("rst_res", res, 8'h00);
        chk("rst_vld", {7'b0, res_valid}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back stream: cycle k issues op k while the ALU presents op k-1.
        for (int k = 0; k <= ops.size(); k++) begin
            if (k < ops.size()) drive_ctl(ops[k], 1'b1);
            else                drive_ctl(zero_op, 1'b0);
            if (k >= 1) begin
                drive_alu(ops[k-1]);
                exp_res_q.push_back(ops[k-1].exp_res);
                exp_p_q.push_back(ops[k-1].exp_p);
            end
            @(posedge clk); #1;
            if (k >= 1) begin
                er = exp_res_q.pop_front();
                ep = exp_p_q.pop_front();
                chk($sformatf("op%0d_vld", k-1), {7'b0, res_valid}, 8'h01);
                chk($sformatf("op%0d_res", k-1), res, er);
                chk($sformatf("op%0d_p", k-1), P, ep);
                chk($sformatf("op%0d_cd", k-1), {6'b0, d_flag, c_flag}, {6'b0, ep[3], ep[0]});
            end
        end
        last_res = ops[ops.size()-1].exp_res;

        drive_alu(zero_op);
        @(posedge clk); #1;
        chk("idle_vld", {7'b0, res_valid}, 8'h00);
        chk("idle_res", res, last_res);
        chk("idle_p", P, 8'h7B);

        // Stall with an op waiting to issue; irq during the stall is ignored.
        cur = mk(2'b01, 0, 1, 0, 0, 0, 0, 2'b00, 0, 8'h00, 8'h4C, 0, 0, 0, 0, 1, 0, 8'h42, 8'h7A);
        RDY = 1'b0;
        drive_ctl(cur, 1'b1);
        irq_set_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_p", i), P, 8'h7B);
            chk($sformatf("stall%0d_res", i), res, last_res);
            chk($sformatf("stall%0d_vld", i), {7'b0, res_valid}, 8'h00);
        end
        irq_set_i = 1'b0;
        RDY = 1'b1;
        @(posedge clk); #1;
        chk("stall_edge1_vld", {7'b0, res_valid}, 8'h00);
        drive_ctl(zero_op, 1'b0);
        drive_alu(cur);
        irq_set_i = 1'b0;
        exp_res_q.push_back(cur.exp_res);
        exp_p_q.push_back(cur.exp_p);
        @(posedge clk); #1;
        chk("stall_edge2_vld", {7'b0, res_valid}, 8'h01);
        chk("stall_edge2_res", res, exp_res_q.pop_front());
        chk("stall_edge2_p", P, exp_p_q.pop_front());

        // Asynchronous reset with an op sitting in stage 1.
        cur = mk(2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 0, 8'h00, 8'h99, 1, 0, 0, 0, 0, 0, 8'h99, 8'h7B);
        drive_ctl(cur, 1'b1);
        @(posedge clk); #1;
        drive_ctl(zero_op, 1'b0);
        drive_alu(cur);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_p", P, 8'h34);
        chk("mid_rst_res", res, 8'h00);
        chk("mid_rst_vld", {7'b0, res_valid}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst%0d_vld", i), {7'b0, res_valid}, 8'h00);
            chk($sformatf("post_rst%0d_p", i), P, 8'h34);
            chk($sformatf("post_rst%0d_res", i), res, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
